// File: rtl/palette_pkg.sv
// Shared types for the sprite palette lookup arbiter: colour word, palette depth, controller states.
package palette_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int PAL_DEPTH = 16;
  localparam int IDX_W     = 4;

  typedef enum logic {INIT, RUN} pal_state_t;

  // Index 0 is reserved as the see-through colour in every bank.
  function automatic logic is_transparent(input logic [IDX_W-1:0] idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Lookup request/response and palette config buses between requesters, loader and the palette arbiter.
interface palette_lookup_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int BANK_W = 2
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                    req_valid;
  logic [NREQ-1:0]                    req_ready;
  logic [NREQ*BANK_W-1:0]             req_bank;
  logic [NREQ*palette_pkg::IDX_W-1:0] req_index;

  logic            rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [3:0]      red;
  logic [3:0]      green;
  logic [3:0]      blue;
  logic            rsp_transparent;

  logic                        cfg_wr_valid;
  logic                        cfg_wr_ready;
  logic [BANK_W-1:0]           cfg_bank;
  logic [palette_pkg::IDX_W-1:0] cfg_index;
  palette_pkg::rgb12_t         cfg_rgb;

  modport master (
    output req_valid, req_bank, req_index, cfg_wr_valid, cfg_bank, cfg_index, cfg_rgb,
    input  req_ready, rsp_valid, rsp_id, red, green, blue, rsp_transparent, cfg_wr_ready
  );

  modport slave (
    input  req_valid, req_bank, req_index, cfg_wr_valid, cfg_bank, cfg_index, cfg_rgb,
    output req_ready, rsp_valid, rsp_id, red, green, blue, rsp_transparent, cfg_wr_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr (mod N); purely combinational.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any_gnt
);

  logic [W:0]   sum;
  logic [W-1:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      pos = sum[W-1:0];
      if (!any_gnt && req[pos]) begin
        any_gnt  = 1'b1;
        gnt_idx  = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Banked writable sprite palette shared by NREQ requesters; one lookup or config write per cycle,
// lookup response registered 1 cycle after the transfer, no response back-pressure.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int NBANK    = 4,
  parameter int BANK_W   = 2,
  parameter int MAX_WAIT = 8
) (
  input logic Clk,
  input logic Reset_n,
  palette_lookup_arbiter_if.slave bus
);

  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBANK * PAL_DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  pal_state_t        state_q, state_d;
  logic              run;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [WAIT_W-1:0] wait_cnt_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              cfg_win;
  logic              lkp_win;
  logic [BANK_W-1:0] lkp_bank;
  logic [IDX_W-1:0]  lkp_index;

  rgb12_t            pal_mem [NBANK*PAL_DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  rgb12_t            mem_wdat;
  rgb12_t            rd_q;
  logic              rd_vld_q;
  logic              rsp_vld_q;
  logic              rsp_transp_q;
  logic [ID_W-1:0]   rsp_id_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      INIT:    if (clr_cnt_q == LAST_ADDR) state_d = RUN;
      RUN:     run = 1'b1;
      default: state_d = INIT;
    endcase
  end

  // A waiting config write only pre-empts lookups once it has been starved MAX_WAIT cycles.
  assign cfg_win = run && bus.cfg_wr_valid && (!arb_any || wait_cnt_q == WAIT_MAX);
  assign lkp_win = run && arb_any && !cfg_win;

  assign bus.req_ready    = lkp_win ? arb_gnt : '0;
  assign bus.cfg_wr_ready = cfg_win;

  always_comb begin
    lkp_bank  = '0;
    lkp_index = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        lkp_bank  = bus.req_bank[i*BANK_W +: BANK_W];
        lkp_index = bus.req_index[i*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == INIT) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      if (lkp_win) rr_ptr_q <= (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);
      if (cfg_win || !bus.cfg_wr_valid || !run) wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_MAX)          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  assign mem_we    = (state_q == INIT) || cfg_win;
  assign mem_waddr = (state_q == INIT) ? clr_cnt_q : {bus.cfg_bank, bus.cfg_index};
  assign mem_wdat  = (state_q == INIT) ? '0 : bus.cfg_rgb;

  always_ff @(posedge Clk) begin
    if (mem_we)  pal_mem[mem_waddr] <= mem_wdat;
    if (lkp_win) rd_q <= pal_mem[{lkp_bank, lkp_index}];
  end

  // rd_q has no reset; rd_vld_q forces the colour outputs to 0 until the first lookup after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_vld_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rsp_id_q     <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      rsp_vld_q <= lkp_win;
      if (lkp_win) begin
        rd_vld_q     <= 1'b1;
        rsp_id_q     <= arb_idx;
        rsp_transp_q <= is_transparent(lkp_index);
      end
    end
  end

  assign bus.rsp_valid       = rsp_vld_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_transparent = rsp_transp_q;
  assign {bus.red, bus.green, bus.blue} = rd_vld_q ? rd_q : '0;

endmodule
